// File: rtl/diagram_checker.sv
// diagram_checker
//   Drives a short stimulus sequence into an external registered device and
//   compares the device's response, one cycle later, against a held-XNOR
//   reference. A run is PRIME (a=b=1) followed by N vectors taken from
//   vec_a/vec_b. The response to each is compared on the following cycle,
//   so there are N+1 compares. The last compare happens in CHECK, after
//   stimulus has stopped.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle run request, honoured only in IDLE
//   num_steps  : vector count 1..8 (0 selects 8)
//   vec_a/b    : bit i is the a/b stimulus for vector i
//   dut_y      : registered response of the device under check
//   a, b       : registered stimulus to the device under check
//   busy       : high from PRIME through CHECK
//   done       : one-cycle pulse at the end of a run
//   pass, fail : verdict, held until the next accepted start
//   fail_step  : index of the first mismatching compare
//   step_cnt   : number of compares completed
module diagram_checker #(
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_steps,
  input  logic [7:0] vec_a,
  input  logic [7:0] vec_b,
  input  logic       dut_y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [3:0] fail_step,
  output logic [3:0] step_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;
  logic [3:0] fstep_q, fstep_d;
  logic [3:0] scnt_q, scnt_d;
  logic       ha_q, ha_d;
  logic       hb_q, hb_d;
  logic       mism_q, mism_d;   // any mismatch seen so far in this run
  logic [3:0] n_q, n_d;
  logic [7:0] va_q, va_d;
  logic [7:0] vb_q, vb_d;

  logic       ref_y;
  logic       mism;
  logic       any_mism;
  logic       last_vec;
  logic [2:0] nxt_idx;

  assign ref_y    = ~(ha_q ^ hb_q);
  assign mism     = (dut_y != ref_y);
  assign any_mism = mism_q | mism;
  // step_cnt equals the index of the vector currently on a/b while in RUN
  assign last_vec = (scnt_q == (n_q - 4'd1));
  assign nxt_idx  = scnt_q[2:0] + 3'd1;

  always_comb begin
    state_d = state_q;
    a_d     = 1'b0;
    b_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    fstep_d = fstep_q;
    scnt_d  = scnt_q;
    ha_d    = ha_q;
    hb_d    = hb_q;
    mism_d  = mism_q;
    n_d     = n_q;
    va_d    = va_q;
    vb_d    = vb_q;

    // The reference pair follows the stimulus applied in PRIME/RUN, with
    // a&b collapsing to (0,0).
    if (state_q == PRIME || state_q == RUN) begin
      ha_d = (a_q & b_q) ? 1'b0 : a_q;
      hb_d = (a_q & b_q) ? 1'b0 : b_q;
    end

    // Every RUN and CHECK cycle is one compare.
    if (state_q == RUN || state_q == CHECK) begin
      scnt_d = scnt_q + 4'd1;
      if (mism && !mism_q) begin
        fstep_d = scnt_q;
        mism_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          // Out-of-range counts are treated like 0, i.e. the full 8 vectors.
          n_d     = (num_steps == 4'd0 || num_steps > 4'd8) ? 4'd8 : num_steps;
          va_d    = vec_a;
          vb_d    = vec_b;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          fstep_d = 4'd0;
          scnt_d  = 4'd0;
          mism_d  = 1'b0;
          a_d     = 1'b1;
          b_d     = 1'b1;
          busy_d  = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        a_d     = va_q[0];
        b_d     = vb_q[0];
        state_d = RUN;
      end
      RUN: begin
        if (mism && STOP_ON_FAIL) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b1;
          state_d = DONE;
        end else if (last_vec) begin
          state_d = CHECK;
        end else begin
          a_d = va_q[nxt_idx];
          b_d = vb_q[nxt_idx];
        end
      end
      CHECK: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = ~any_mism;
        fail_d  = any_mism;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      fstep_q <= 4'd0;
      scnt_q  <= 4'd0;
      ha_q    <= 1'b0;
      hb_q    <= 1'b0;
      mism_q  <= 1'b0;
      n_q     <= 4'd0;
      va_q    <= 8'd0;
      vb_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fstep_q <= fstep_d;
      scnt_q  <= scnt_d;
      ha_q    <= ha_d;
      hb_q    <= hb_d;
      mism_q  <= mism_d;
      n_q     <= n_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_step = fstep_q;
  assign step_cnt  = scnt_q;

endmodule
